// File: rtl/tagger_tag_encoder.sv
// Tag encoder: per-channel one-deep event slots plus a rollover marker,
// arbitrated in epoch order into a first-word-fall-through output FIFO.
module tagger_tag_encoder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] counter,
    input  logic        rollover,
    input  logic [7:0]  event_in,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    pend_q, pend_d;
    logic [7:0]    ep_q, ep_d;
    logic [15:0]   stamp_q [8];
    logic          epoch_q, epoch_d;
    logic          mk_q, mk_d;
    logic [15:0]   roll_q, roll_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;

    logic [7:0]  old_v, cap, lost, drain;
    logic [2:0]  sel_ch;
    logic        sel_mk, push, pop, mk_drain;
    logic [3:0]  nlost;
    logic [16:0] drop_sum;
    logic [31:0] push_data;

    // Stale-epoch slots go before the marker so it separates the epochs.
    always_comb begin
        old_v  = pend_q & (ep_q ^ {8{epoch_q}});
        sel_ch = 3'd0;
        sel_mk = 1'b0;
        if (|old_v) begin
            for (int i = 7; i >= 0; i--)
                if (old_v[i]) sel_ch = 3'(i);
        end else if (mk_q) begin
            sel_mk = 1'b1;
        end else begin
            for (int i = 7; i >= 0; i--)
                if (pend_q[i]) sel_ch = 3'(i);
        end
        push      = (cnt_q < FULL_CNT) && (mk_q || (|pend_q));
        mk_drain  = push && sel_mk;
        drain     = (push && !sel_mk) ? (8'd1 << sel_ch) : 8'd0;
        push_data = sel_mk ? {1'b1, 15'd0, roll_q}
                           : {5'd0, sel_ch, 8'd0, stamp_q[sel_ch]};
    end

    always_comb begin
        epoch_d = epoch_q ^ rollover;
        cap     = event_in & (~pend_q | drain);
        lost    = event_in & pend_q & ~drain;
        pend_d  = (pend_q & ~drain) | cap;
        ep_d    = (ep_q & ~cap) | (cap & {8{epoch_d}});
        roll_d  = roll_q + {15'd0, rollover};
        mk_d    = rollover | (mk_q & ~mk_drain);
        nlost   = 4'd0;
        for (int i = 0; i < 8; i++)
            nlost = nlost + {3'd0, lost[i]};
        drop_sum = {1'b0, drop_q} + {13'd0, nlost};
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        ovf_d    = ovf_q | (|lost) | (rollover & mk_q & ~mk_drain);
    end

    assign out_valid  = (cnt_q != '0);
    assign out_data   = out_valid ? mem_q[rptr_q] : 32'd0;
    assign pop        = out_valid && out_ready;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            ep_q    <= '0;
            epoch_q <= 1'b0;
            mk_q    <= 1'b0;
            roll_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            ep_q    <= ep_d;
            epoch_q <= epoch_d;
            mk_q    <= mk_d;
            roll_q  <= roll_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Data storage carries no reset; validity lives in pend_q and cnt_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            if (cap[i]) stamp_q[i] <= counter;
        if (push) mem_q[wptr_q] <= push_data;
    end

endmodule

// File: tb/tb_tagger_tag_encoder.sv
// Scoreboard bench for tagger_tag_encoder: directed scenarios plus
// randomized traffic checked against a queue-based reference model.
module tb_tagger_tag_encoder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] counter = 16'h0;
    logic        rollover = 1'b0;
    logic [7:0]  event_in = 8'h0;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        overflow;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tagger_tag_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .counter(counter),
        .rollover(rollover),
        .event_in(event_in),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    // Reference model state
    logic [15:0] m_stamp [8];
    bit          m_pend [8];
    bit          m_ep [8];
    bit          m_epoch;
    bit          m_mk;
    bit          m_ovf;
    logic [15:0] m_roll;
    int          m_drop;
    int          m_occ;
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = 0;
            m_ep[i] = 0;
            m_stamp[i] = 16'h0;
        end
        m_epoch = 0;
        m_mk = 0;
        m_ovf = 0;
        m_roll = 16'h0;
        m_drop = 0;
        m_occ = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int  pick;
        bit  pick_mk;
        bit  popped;
        bit  wrote;
        pick = -1;
        pick_mk = 0;
        wrote = 0;
        popped = (m_occ > 0) && out_ready;
        if (m_occ < DEPTH) begin
            for (int i = 0; i < 8; i++)
                if (pick < 0 && m_pend[i] && m_ep[i] != m_epoch) pick = i;
            if (pick < 0 && m_mk) begin
                pick_mk = 1;
            end else if (pick < 0) begin
                for (int i = 0; i < 8; i++)
                    if (pick < 0 && m_pend[i]) pick = i;
            end
        end
        if (pick_mk) begin
            exp_q.push_back({1'b1, 15'd0, m_roll});
            m_mk = 0;
            wrote = 1;
        end else if (pick >= 0) begin
            exp_q.push_back({5'd0, 3'(pick), 8'd0, m_stamp[pick]});
            m_pend[pick] = 0;
            wrote = 1;
        end
        m_occ = m_occ + int'(wrote) - int'(popped);
        if (rollover) begin
            m_epoch = !m_epoch;
            m_roll = m_roll + 16'd1;
            if (m_mk) m_ovf = 1;
            m_mk = 1;
        end
        for (int i = 0; i < 8; i++) begin
            if (event_in[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1;
                    m_stamp[i] = counter;
                    m_ep[i] = m_epoch;
                end else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    // Monitor: compares every handshake against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 32'(out_valid), 32'(m_occ != 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("drop_count", 32'(drop_count), 32'(m_drop));
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word: got %h, want none", out_data);
                end else begin
                    check("word", out_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic [7:0] ev, input logic [15:0] c,
                         input logic ro, input logic rdy);
        event_in = ev;
        counter = c;
        rollover = ro;
        out_ready = rdy;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_got(input string name, input int idx,
                             input logic [31:0] exp);
        check(name, (idx < got_q.size()) ? got_q[idx] : 32'hDEAD_DEAD, exp);
    endtask

    logic [15:0] ctr;
    int          rdy_pct;
    int          ev_pct;
    logic [7:0]  ev;

    initial begin
        // Inputs active during reset must be ignored.
        drive(8'hFF, 16'h0000, 1'b1, 1'b1);
        step(3);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);

        // Single event, latency
        got_q.delete();
        rst = 1'b0;
        drive(8'h08, 16'h1234, 1'b0, 1'b1);
        step();
        check("lat_edge_n", 32'(out_valid), 32'd0);
        drive(8'h00, 16'h1235, 1'b0, 1'b1);
        step();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", out_data, 32'h0300_1234);
        step(3);
        check("single_cnt", 32'(got_q.size()), 32'd1);
        check_got("single_w", 0, 32'h0300_1234);

        // Simultaneous events on three channels
        got_q.delete();
        drive(8'hA1, 16'h0010, 1'b0, 1'b1);
        step();
        drive(8'h00, 16'h0011, 1'b0, 1'b1);
        step(6);
        check("multi_cnt", 32'(got_q.size()), 32'd3);
        check_got("multi_w0", 0, 32'h0000_0010);
        check_got("multi_w1", 1, 32'h0500_0010);
        check_got("multi_w2", 2, 32'h0700_0010);

        // Events straddling a rollover
        got_q.delete();
        drive(8'h04, 16'hFFFF, 1'b0, 1'b1);
        step();
        drive(8'h02, 16'h0000, 1'b1, 1'b1);
        step();
        drive(8'h00, 16'h0001, 1'b0, 1'b1);
        step(6);
        check("roll_cnt", 32'(got_q.size()), 32'd3);
        check_got("roll_w0", 0, 32'h0200_FFFF);
        check_got("roll_w1", 1, 32'h8000_0001);
        check_got("roll_w2", 2, 32'h0100_0000);

        // Fill FIFO, then overrun a slot and load all slots while full
        got_q.delete();
        for (int k = 0; k < DEPTH; k++) begin
            drive(8'h01, 16'h0100 + 16'(k), 1'b0, 1'b0);
            step();
        end
        drive(8'h00, 16'h0200, 1'b0, 1'b0);
        step();
        check("full_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive(8'h10, 16'h0300 + 16'(k), 1'b0, 1'b0);
            step();
        end
        drive(8'h00, 16'h0400, 1'b0, 1'b0);
        step();
        check("ovr_drop", 32'(drop_count), 32'd2);
        check("ovr_flag", 32'(overflow), 32'd1);
        drive(8'hFF, 16'h0500, 1'b0, 1'b0);
        step();
        drive(8'h00, 16'h0501, 1'b0, 1'b0);
        step(2);
        check("full_drop", 32'(drop_count), 32'd3);
        drive(8'h00, 16'h0502, 1'b0, 1'b1);
        step(DEPTH + 12);
        check("drain_cnt", 32'(got_q.size()), 32'(DEPTH + 8));
        for (int k = 0; k < DEPTH; k++)
            check_got("drain_fill", k, 32'h0000_0100 + 32'(k));
        for (int i = 0; i < 8; i++)
            check_got("drain_slot", DEPTH + i,
                      (i == 4) ? 32'h0400_0300
                               : {5'd0, 3'(i), 8'd0, 16'h0500});

        // Reset with words queued and slots pending
        got_q.delete();
        for (int k = 0; k < 5; k++) begin
            drive(8'h01, 16'h0700 + 16'(k), 1'b0, 1'b0);
            step();
        end
        drive(8'h06, 16'h0710, 1'b0, 1'b0);
        step();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        drive(8'h00, 16'h0711, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_drop", 32'(drop_count), 32'd0);
        drive(8'hFF, 16'h0000, 1'b1, 1'b1);
        step(2);
        rst = 1'b0;
        drive(8'h40, 16'h0ABC, 1'b0, 1'b1);
        step();
        check("post_rst_n", 32'(out_valid), 32'd0);
        drive(8'h00, 16'h0ABD, 1'b0, 1'b1);
        step();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", out_data, 32'h0600_0ABC);
        step(4);
        check("post_rst_cnt", 32'(got_q.size()), 32'd1);
        check_got("post_rst_w", 0, 32'h0600_0ABC);

        // Randomized traffic
        ctr = 16'hFFF0;
        rdy_pct = 100;
        ev_pct = 10;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                rdy_pct = int'($urandom_range(10, 100));
                ev_pct = int'($urandom_range(0, 60));
            end
            if ($urandom_range(0, 15) == 0)
                ctr = 16'hFFFF - 16'($urandom_range(0, 3));
            else
                ctr = ctr + 16'd1;
            ev = 8'h00;
            for (int i = 0; i < 8; i++)
                ev[i] = (int'($urandom_range(0, 99)) < ev_pct);
            drive(ev, ctr, ctr == 16'h0000,
                  int'($urandom_range(0, 99)) < rdy_pct);
            if (c == 1500) begin
                #2;
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        drive(8'h00, ctr + 16'd1, 1'b0, 1'b1);
        step(DEPTH + 20);
        check("leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tagger_tag_encoder.md
TAGGER_TAG_ENCODER -- requirements
Module: tagger_tag_encoder

Interface
REQ-001 Parameter: FIFO_DEPTH, 16, output FIFO depth in words; power of two, 4..64.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 counter  input  16  free-running timebase from the upstream 16-bit counter stage.
REQ-005 rollover  input  1  one-cycle flag, high in the cycle counter reads 0x0000 after a wrap.
REQ-006 event_in  input  8  per-channel event pulses, already synchronous to clk; may be high on consecutive cycles.
REQ-007 out_data  output  32  tag word at FIFO head.
REQ-008 out_valid  output  1  FIFO not empty.
REQ-009 out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-010 overflow  output  1  sticky; any event or rollover marker lost.
REQ-011 drop_count  output  16  count of lost channel events, saturating.

Function
REQ-012 Event word: [31]=0, [30:27]=0, [26:24]=channel index, [23:16]=0, [15:0]=captured counter value.
REQ-013 Marker word: [31]=1, [30:16]=0, [15:0]=roll_cnt value after its increment.
REQ-014 Each channel has a one-deep pending slot holding stamp[15:0] and epoch bit.
REQ-015 Capture: event_in[i] high at an edge and slot i empty (or drained that same edge) -> slot i loads counter and epoch, becomes pending.
REQ-016 Epoch register toggles on each edge with rollover=1; an event in a rollover=1 cycle takes the new (toggled) epoch.
REQ-017 Event at slot i while pending and not drained that edge -> event lost, overflow set, drop_count +1 (saturates at 0xFFFF).
REQ-018 Rollover=1 -> roll_cnt increments (wraps at 16 bits), marker pending set.
REQ-019 Rollover while marker still pending and not drained that edge -> overflow set; single marker remains, carrying latest roll_cnt.
REQ-020 Arbiter writes at most one word per cycle, only when FIFO occupancy < FIFO_DEPTH (registered occupancy; no push-on-pop when full).
REQ-021 Priority: (a) lowest-index pending slot whose epoch != current epoch, (b) marker, (c) lowest-index pending slot.
REQ-022 Consequence: every event of epoch k precedes marker k+1, which precedes every event of epoch k+1 in the output stream.
REQ-023 Written slot/marker clears on the same edge as the FIFO write.
REQ-024 FIFO first-word-fall-through; out_data valid combinationally with out_valid; pop on out_valid && out_ready.
REQ-025 Simultaneous push and pop: occupancy unchanged, both take effect.
REQ-026 Latency: event at edge N, empty FIFO, no contention -> written at edge N+1, out_valid high after edge N+1 (visible cycle N+1..).
REQ-027 out_data holds stable while out_valid && !out_ready.
REQ-028 No word ever duplicated or reordered relative to REQ-021.

Reset
REQ-029 rst high -> immediately: FIFO empty, out_valid=0, out_data=0, all slots empty, marker not pending, epoch=0, roll_cnt=0, overflow=0, drop_count=0.
REQ-030 Events and rollover while rst high are ignored; first capture on first edge after rst deasserts.
REQ-031 rst mid-stream discards all pending and queued words; no partial words emitted.

Verification
REQ-032 Single event ch3 at counter=0x1234, out_ready=1 -> one word 0x03001234, out_valid one cycle later.
REQ-033 Events ch0,ch5,ch7 same cycle at counter=0x0010 -> words 0x00000010, 0x05000010, 0x07000010 in that order on consecutive cycles.
REQ-034 Event ch2 at counter=0xFFFF, event ch1 next cycle (counter=0x0000, rollover=1) -> 0x0200FFFF, 0x80000001, 0x01000000.
REQ-035 out_ready=0, event_in[4] high for 3 cycles -> first captured, next two lost once slot full; drop_count=2, overflow=1.
REQ-036 out_ready=0 until FIFO holds FIFO_DEPTH words, then events on all channels -> no writes while full, slots hold, drained in order after out_ready=1.
REQ-037 Assert rst with 5 words queued and 2 slots pending -> out_valid=0 at once, all counters 0, next event after release produces correct single word.
